irq_timer_bank: RTL and testbench

//  Parametrised multi-channel timer plus interrupt controller; successor to the fixed single-period timer.
//  - Each channel counts clk cycles to its own programmable period.
//  - On terminal count a channel raises a pending bit; pending bits are prioritised into one irq/irq_id pair.
//  - The CPU acknowledges an interrupt through an ack handshake.
//  - Sits beside cpu and i_o_manager in cpu_environment; the pending vector replaces interruptions[7:0].

---
 rtl/irq_timer_bank_pkg.sv | 24 ++
 rtl/irq_timer_bank_if.sv | 31 +++
 rtl/irq_timer_bank_timer_channel.sv | 51 +++++
 rtl/irq_timer_bank.sv | 88 ++++++++
 tb/tb_irq_timer_bank.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/irq_timer_bank_pkg.sv
// Shared constants and types for the multi-channel timer and interrupt controller.
package irq_timer_pkg;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_MASK     = 2;

  localparam int DEFAULT_N_CH       = 8;
  localparam int DEFAULT_CNT_W      = 28;
  localparam int DEFAULT_PERIOD     = 10;
  localparam bit DEFAULT_RESET_EN0  = 1'b1;

  typedef struct packed {
    logic mask_en;
    logic periodic;
    logic enable;
  } ctrl_t;

  // Index width never collapses to zero, even for a single channel.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_timer_bank_if.sv
// CPU-facing configuration, acknowledge and interrupt signals of the timer bank.
interface irq_timer_bank_if
  import irq_timer_pkg::*;
#(
  parameter int N_CH  = DEFAULT_N_CH,
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int ID_W  = id_width(N_CH)
);

  logic             cfg_we;
  logic [ID_W-1:0]  cfg_sel;
  logic [CNT_W-1:0] cfg_period;
  logic [2:0]       cfg_ctrl;
  logic             irq_ack;
  logic [ID_W-1:0]  ack_id;
  logic             irq;
  logic [ID_W-1:0]  irq_id;
  logic [N_CH-1:0]  interruptions;
  logic [N_CH-1:0]  overrun;

  modport master (
    output cfg_we, cfg_sel, cfg_period, cfg_ctrl, irq_ack, ack_id,
    input  irq, irq_id, interruptions, overrun
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_period, cfg_ctrl, irq_ack, ack_id,
    output irq, irq_id, interruptions, overrun
  );

endinterface

// File: rtl/irq_timer_bank_timer_channel.sv
// One timer channel: counter, period and control registers plus a terminal-event pulse.
module timer_channel
  import irq_timer_pkg::*;
#(
  parameter int         CNT_W      = DEFAULT_CNT_W,
  parameter int         DEF_PERIOD = DEFAULT_PERIOD,
  parameter logic [2:0] RESET_CTRL = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_period,
  input  logic [2:0]       load_ctrl,
  output logic             mask_en,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [2:0]       ctrl;
  logic             running;
  logic             terminal;

  always_comb begin
    running  = ctrl[CTRL_EN] && (period != '0);
    terminal = running && (cnt == period - CNT_W'(1));
    // A config write on the terminal cycle swallows that event.
    tick     = terminal && !load;
    mask_en  = ctrl[CTRL_MASK];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      period <= CNT_W'(DEF_PERIOD);
      ctrl   <= RESET_CTRL;
    end else if (load) begin
      cnt    <= '0;
      period <= load_period;
      ctrl   <= load_ctrl;
    end else if (terminal) begin
      cnt <= '0;
      if (!ctrl[CTRL_PERIODIC]) ctrl[CTRL_EN] <= 1'b0;
    end else if (running) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/irq_timer_bank.sv
// Multi-channel timer bank with pending/overrun tracking and a lowest-index priority interrupt.
module irq_timer_bank
  import irq_timer_pkg::*;
#(
  parameter int N_CH       = DEFAULT_N_CH,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int DEF_PERIOD = DEFAULT_PERIOD,
  parameter bit RESET_EN0  = DEFAULT_RESET_EN0
) (
  input logic               clk,
  input logic               reset,
  irq_timer_bank_if.slave   bus
);

  localparam int ID_W = id_width(N_CH);

  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] mask_en;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] overrun;
  logic [N_CH-1:0] ack_hit;
  logic [N_CH-1:0] eligible;
  logic            any_eligible;
  logic [ID_W-1:0] low_id;
  logic            irq_q;
  logic [ID_W-1:0] irq_id_q;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    timer_channel #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .RESET_CTRL ((ch == 0 && RESET_EN0) ? 3'b111 : 3'b000)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .load        (bus.cfg_we && (bus.cfg_sel == ID_W'(ch))),
      .load_period (bus.cfg_period),
      .load_ctrl   (bus.cfg_ctrl),
      .mask_en     (mask_en[ch]),
      .tick        (tick[ch])
    );
  end

  // Out-of-range ack_id matches no channel, so it falls out naturally.
  always_comb begin
    ack_hit      = '0;
    eligible     = pending & mask_en;
    any_eligible = |eligible;
    low_id       = '0;
    for (int i = 0; i < N_CH; i++) begin
      ack_hit[i] = bus.irq_ack && (bus.ack_id == ID_W'(i));
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) low_id = ID_W'(i);
    end
  end

  // A new event beats a same-cycle ack; the ack still consumes the old event, so no overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (tick[i])         pending[i] <= 1'b1;
        else if (ack_hit[i]) pending[i] <= 1'b0;
        if (ack_hit[i])                  overrun[i] <= 1'b0;
        else if (tick[i] && pending[i])  overrun[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      irq_q <= any_eligible;
      if (any_eligible) irq_id_q <= low_id;
    end
  end

  assign bus.irq           = irq_q;
  assign bus.irq_id        = irq_id_q;
  assign bus.interruptions = pending;
  assign bus.overrun       = overrun;

endmodule

// File: tb/tb_irq_timer_bank.sv
// Directed self-checking bench for irq_timer_bank with seven channels so cfg_sel=N_CH is expressible.
module tb_irq_timer_bank;

  localparam int N_CH  = 7;
  localparam int CNT_W = 28;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  irq_timer_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  irq_timer_bank #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .DEF_PERIOD (10),
    .RESET_EN0  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %0h, required %0h", tag, observed, expected);
      end
  endtask

  task automatic apply_cfg(input int sel, input int period, input logic [2:0] ctrl);
    bus.cfg_we     = 1'b1;
    bus.cfg_sel    = 3'(sel);
    bus.cfg_period = CNT_W'(period);
    bus.cfg_ctrl   = ctrl;
    cycles(1);
    bus.cfg_we     = 1'b0;
  endtask

  task automatic apply_ack(input int id);
    bus.irq_ack = 1'b1;
    bus.ack_id  = 3'(id);
    cycles(1);
    bus.irq_ack = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_sel    = '0;
    bus.cfg_period = '0;
    bus.cfg_ctrl   = '0;
    bus.irq_ack    = 1'b0;
    bus.ack_id     = '0;

    #1;
    check_output("reset_pending", 32'(bus.interruptions), 32'h0);
    check_output("reset_irq", 32'(bus.irq), 32'h0);
    check_output("reset_irq_id", 32'(bus.irq_id), 32'h0);
    check_output("reset_overrun", 32'(bus.overrun), 32'h0);
    cycles(2);
    reset = 1'b1;

    // Channel 0 comes up enabled with the default period of 10.
    cycles(9);
    check_output("t1_no_event_at_9", 32'(bus.interruptions), 32'h0);
    cycles(1);
    check_output("t1_pending_at_10", 32'(bus.interruptions), 32'h01);
    check_output("t1_irq_low_at_10", 32'(bus.irq), 32'h0);
    cycles(1);
    check_output("t1_irq_at_11", 32'(bus.irq), 32'h1);
    check_output("t1_irq_id_at_11", 32'(bus.irq_id), 32'h0);
    apply_cfg(0, 10, 3'b000);
    apply_ack(0);
    cycles(2);
    check_output("t1_cleared_pending", 32'(bus.interruptions), 32'h0);
    check_output("t1_cleared_irq", 32'(bus.irq), 32'h0);

    // Periodic ch3 vs one-shot ch5, both period 5; ch5 loaded one cycle earlier.
    apply_cfg(5, 5, 3'b101);
    apply_cfg(3, 5, 3'b111);
    cycles(3);
    check_output("t2_none_yet", 32'(bus.interruptions), 32'h00);
    cycles(1);
    check_output("t2_ch5_event", 32'(bus.interruptions), 32'h20);
    cycles(1);
    check_output("t2_ch3_event", 32'(bus.interruptions), 32'h28);
    check_output("t2_irq_id_5", 32'(bus.irq_id), 32'h5);
    cycles(1);
    check_output("t2_irq_id_3", 32'(bus.irq_id), 32'h3);
    apply_ack(5);
    apply_ack(3);
    cycles(2);
    check_output("t2_ch3_refire_ch5_silent", 32'(bus.interruptions), 32'h08);
    cycles(5);
    check_output("t2_ch5_still_silent", 32'(bus.interruptions), 32'h08);
    check_output("t2_ch3_overrun", 32'(bus.overrun), 32'h08);
    apply_cfg(3, 5, 3'b000);
    apply_ack(3);
    cycles(2);
    check_output("t2_all_clear", 32'(bus.interruptions), 32'h0);
    check_output("t2_overrun_clear", 32'(bus.overrun), 32'h0);
    check_output("t2_irq_clear", 32'(bus.irq), 32'h0);

    // Priority: ch2 and ch6 pending together, lowest index first.
    apply_cfg(2, 3, 3'b101);
    apply_cfg(6, 3, 3'b101);
    cycles(4);
    check_output("t3_both_pending", 32'(bus.interruptions), 32'h44);
    check_output("t3_irq_id_2", 32'(bus.irq_id), 32'h2);
    apply_ack(2);
    check_output("t3_after_ack2_pending", 32'(bus.interruptions), 32'h40);
    check_output("t3_irq_id_latency", 32'(bus.irq_id), 32'h2);
    cycles(1);
    check_output("t3_irq_id_6", 32'(bus.irq_id), 32'h6);
    apply_ack(6);
    check_output("t3_irq_still_high", 32'(bus.irq), 32'h1);
    cycles(1);
    check_output("t3_irq_dropped", 32'(bus.irq), 32'h0);
    check_output("t3_irq_id_holds", 32'(bus.irq_id), 32'h6);

    // Overrun on unacked ch1, then an ack landing on the terminal cycle.
    apply_cfg(1, 4, 3'b111);
    cycles(4);
    check_output("t4_first_event", 32'(bus.interruptions), 32'h02);
    check_output("t4_no_overrun_yet", 32'(bus.overrun), 32'h00);
    cycles(4);
    check_output("t4_overrun_set", 32'(bus.overrun), 32'h02);
    apply_ack(1);
    check_output("t4_ack_clears_overrun", 32'(bus.overrun), 32'h00);
    check_output("t4_ack_clears_pending", 32'(bus.interruptions), 32'h00);
    cycles(2);
    apply_ack(1);
    check_output("t4_collision_pending", 32'(bus.interruptions), 32'h02);
    check_output("t4_collision_no_overrun", 32'(bus.overrun), 32'h00);
    cycles(4);
    check_output("t4_overrun_again", 32'(bus.overrun), 32'h02);
    apply_cfg(1, 4, 3'b000);
    apply_ack(1);

    // Masked ch4 stays pending without raising irq; unmasking raises it a cycle later.
    apply_cfg(4, 2, 3'b001);
    cycles(3);
    check_output("t5_masked_pending", 32'(bus.interruptions), 32'h10);
    check_output("t5_masked_no_irq", 32'(bus.irq), 32'h0);
    apply_cfg(4, 2, 3'b100);
    check_output("t5_cfg_keeps_pending", 32'(bus.interruptions), 32'h10);
    check_output("t5_irq_not_yet", 32'(bus.irq), 32'h0);
    cycles(1);
    check_output("t5_unmask_irq", 32'(bus.irq), 32'h1);
    check_output("t5_unmask_irq_id", 32'(bus.irq_id), 32'h4);
    apply_ack(7);
    check_output("t5_bad_ack_ignored", 32'(bus.interruptions), 32'h10);
    apply_cfg(7, 1, 3'b111);
    cycles(20);
    check_output("t5_bad_cfg_ignored", 32'(bus.interruptions), 32'h10);
    check_output("t5_bad_cfg_no_overrun", 32'(bus.overrun), 32'h00);
    apply_cfg(6, 0, 3'b111);
    cycles(100);
    check_output("t5_period0_silent", 32'(bus.interruptions), 32'h10);
    check_output("t5_irq_id_still_4", 32'(bus.irq_id), 32'h4);

    // Async reset at count 7 of 10 on ch0, with ch4 still pending and irq high.
    apply_cfg(0, 10, 3'b111);
    cycles(7);
    check_output("t6_irq_before_reset", 32'(bus.irq), 32'h1);
    reset = 1'b0;
    #1;
    check_output("t6_reset_pending", 32'(bus.interruptions), 32'h0);
    check_output("t6_reset_irq", 32'(bus.irq), 32'h0);
    check_output("t6_reset_irq_id", 32'(bus.irq_id), 32'h0);
    check_output("t6_reset_overrun", 32'(bus.overrun), 32'h0);
    cycles(2);
    reset = 1'b1;
    cycles(9);
    check_output("t6_no_event_at_9", 32'(bus.interruptions), 32'h0);
    cycles(1);
    check_output("t6_event_at_10", 32'(bus.interruptions), 32'h01);
    cycles(1);
    check_output("t6_irq_at_11", 32'(bus.irq), 32'h1);
    check_output("t6_irq_id_at_11", 32'(bus.irq_id), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
